// File: rtl/rv32i_types.sv
// Shared RV32IM decode types: functional-unit select, operation encodings and
// the decoded micro-op that flows from decode to dispatch/rename.
package rv32i_types;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_VARIANT = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {fu_alu, fu_mdu, fu_lsu, fu_br} fu_sel_t;

  // ALU op is {funct7[5], funct3}, so sub/sra land in the upper half.
  typedef enum logic [3:0] {
    alu_op_add  = 4'b0000, alu_op_sll = 4'b0001, alu_op_slt = 4'b0010,
    alu_op_sltu = 4'b0011, alu_op_xor = 4'b0100, alu_op_srl = 4'b0101,
    alu_op_or   = 4'b0110, alu_op_and = 4'b0111, alu_op_sub = 4'b1000,
    alu_op_sra  = 4'b1101
  } alu_op_t;

  typedef enum logic [2:0] {
    mdu_op_mul = 3'b000, mdu_op_mulh = 3'b001, mdu_op_mulhsu = 3'b010,
    mdu_op_mulhu = 3'b011, mdu_op_div = 3'b100, mdu_op_divu = 3'b101,
    mdu_op_rem = 3'b110, mdu_op_remu = 3'b111
  } mdu_op_t;

  // LSU op is {is_store, funct3}.
  typedef enum logic [3:0] {
    lsu_op_lb = 4'b0000, lsu_op_lh = 4'b0001, lsu_op_lw = 4'b0010,
    lsu_op_lbu = 4'b0100, lsu_op_lhu = 4'b0101,
    lsu_op_sb = 4'b1000, lsu_op_sh = 4'b1001, lsu_op_sw = 4'b1010
  } lsu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_sel_t     fu;
    alu_op_t     alu_op_type;
    mdu_op_t     mdu_op_type;
    lsu_op_t     lsu_op_type;
    logic [2:0]  br_f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        rd_we;
    logic        src1_pc;
    logic        use_imm;
    logic [31:0] imm;
    logic        illegal;
  } dec_uop_t;

endpackage

// File: rtl/rv32im_decode_comb.sv
// Purely combinational RV32IM decoder: raw word + PC -> dec_uop_t.
// Illegal words collapse to an all-default ALU uop with illegal=1.
module rv32im_decode_comb
  import rv32i_types::*;
(
  input  instr_t      instr,
  input  logic [31:0] pc,
  output dec_uop_t    uop
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        illegal, rd_en;
  dec_uop_t    d;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    d        = '0;
    d.pc     = pc;
    illegal  = 1'b0;
    rd_en    = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        rd_en     = 1'b1;
        d.use_imm = 1'b1;
        d.imm     = imm_u;
        d.src1_pc = (opcode == OPC_AUIPC);
      end
      OPC_JAL: begin
        d.fu      = fu_br;
        rd_en     = 1'b1;
        d.use_imm = 1'b1;
        d.imm     = imm_j;
      end
      OPC_JALR: begin
        d.fu      = fu_br;
        rd_en     = 1'b1;
        d.use_rs1 = 1'b1;
        d.use_imm = 1'b1;
        d.imm     = imm_i;
      end
      OPC_BRANCH: begin
        d.fu      = fu_br;
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        d.use_imm = 1'b1;
        d.imm     = imm_b;
        d.br_f3   = f3;
      end
      OPC_LOAD: begin
        d.fu          = fu_lsu;
        rd_en         = 1'b1;
        d.use_rs1     = 1'b1;
        d.use_imm     = 1'b1;
        d.imm         = imm_i;
        d.lsu_op_type = lsu_op_t'({1'b0, f3});
        illegal       = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        d.fu          = fu_lsu;
        d.use_rs1     = 1'b1;
        d.use_rs2     = 1'b1;
        d.use_imm     = 1'b1;
        d.imm         = imm_s;
        d.lsu_op_type = lsu_op_t'({1'b1, f3});
        illegal       = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        rd_en         = 1'b1;
        d.use_rs1     = 1'b1;
        d.use_imm     = 1'b1;
        d.alu_op_type = alu_op_t'({(f3 == 3'b101) ? f7[5] : 1'b0, f3});
        // Shift-immediates carry only the shamt; funct7 selects logical/arith.
        if (f3 == 3'b001) begin
          d.imm   = imm_sh;
          illegal = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          d.imm   = imm_sh;
          illegal = (f7 != F7_BASE) && (f7 != F7_VARIANT);
        end else begin
          d.imm   = imm_i;
        end
      end
      OPC_OP: begin
        rd_en     = 1'b1;
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
        case (f7)
          F7_BASE:    d.alu_op_type = alu_op_t'({1'b0, f3});
          F7_VARIANT: begin
            d.alu_op_type = alu_op_t'({1'b1, f3});
            illegal       = (f3 != 3'b000) && (f3 != 3'b101);
          end
          F7_MULDIV: begin
            d.fu          = fu_mdu;
            d.mdu_op_type = mdu_op_t'(f3);
          end
          default:    illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    d.rs1   = d.use_rs1 ? instr[19:15] : 5'd0;
    d.rs2   = d.use_rs2 ? instr[24:20] : 5'd0;
    d.rd    = rd_en ? instr[11:7] : 5'd0;
    d.rd_we = rd_en && (instr[11:7] != 5'd0);

    if (illegal) begin
      d         = '0;
      d.pc      = pc;
      d.illegal = 1'b1;
    end
    uop = d;
  end

endmodule

// File: rtl/rv32im_decode_stage.sv
// Decode stage: decodes one fetch word per cycle into a uop and buffers it in a
// small FIFO so in_ready depends only on registered occupancy.
module rv32im_decode_stage
  import rv32i_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  instr_t      in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output dec_uop_t    out_uop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  dec_uop_t        mem [DEPTH];
  dec_uop_t        dec_uop;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;

  rv32im_decode_comb u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .uop   (dec_uop)
  );

  // Valid/ready: a transfer happens on a side only when valid and ready are both
  // high at the clock edge; valid must hold its payload until accepted, ready
  // never looks at valid, and a flush in the same cycle cancels both transfers.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_uop   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_uop;
  end

endmodule
